fp_acc_sequencer: RTL
=====================

Name: fp_acc_sequencer

Overview:
- Multi-cycle custom-instruction initiator that drives the floating-point accumulator core (x/n/en in; r/xo/xu/ao out).
- On a start it streams COUNT single-precision terms from a valid/ready source into the accumulator, asserting n on the first term, tracks terms in flight through the core latency, then returns the final sum and sticky exception flags with a one-cycle done pulse.
- Sits between the processor custom-instruction port and the accumulator core.

Parameters:
- ACC_LATENCY, 3: acc_en-high clock edges from the accumulator sampling x until acc_r reflects that term.
- CNT_W, 16: width of the term-count operand.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global enable; low freezes all state and forces acc_en=0
- start  in  1  begin a sequence (sampled only in IDLE with clk_en=1)
- count  in  CNT_W  number of terms, latched on start
- term_valid  in  1  source term available
- term_data  in  32  IEEE-754 single term
- term_ready  out  1  sequencer accepts a term this cycle
- acc_x  out  32  registered term to accumulator
- acc_n  out  1  registered "new accumulation" flag to accumulator
- acc_en  out  1  registered accumulator enable
- acc_r  in  32  accumulator running sum
- acc_xo, acc_xu, acc_ao  in  1 each  accumulator overflow / underflow / accumulator-overflow flags
- result  out  32  final sum, held until next start
- xo, xu, ao  out  1 each  sticky flags for the sequence
- done  out  1  one-cycle completion pulse
- busy  out  1  high outside IDLE

Behaviour:
- Reset (asynchronous, active-high; also mid-sequence): state=IDLE. result, acc_x, remaining count, tracker and flags cleared to 0. done, busy, term_ready, acc_n, acc_en all 0. Any in-flight sequence is abandoned and produces no done.
- clk_en=0: every register holds, acc_en driven 0, term_ready=0, no term accepted.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and count>0: latch remaining=count, set first=1, clear xo/xu/ao, go FEED.
  - start=1 and count=0: result<=0, go DONE.
  - start in any other state is ignored.
- FEED:
  - term_ready=1, acc_en<=1.
  - Accept (term_valid & term_ready): acc_x<=term_data, acc_n<=first, first<=0, remaining decrements.
  - Bubble (no valid): acc_x<=0x00000000, acc_n<=0.
  - Last acceptance (remaining==1) goes to DRAIN.
- Tracker:
  - Shift register of ACC_LATENCY+1 entries, each entry {term, last}, shifted every enabled cycle.
  - Entry 0 loads on acceptance.
  - When an entry with term=1 exits, OR acc_xo/acc_xu/acc_ao into sticky xo/xu/ao.
- DRAIN:
  - term_ready=0, acc_en<=1, bubbles as above.
  - When the last-marked entry exits: result<=acc_r, flags updated from that same cycle, go DONE.
- DONE: done=1 for exactly one cycle, acc_en<=0, go IDLE. result/xo/xu/ao stay stable until the next accepted start.
- Timing: start sampled at edge 0 with no bubbles gives acceptances at edges 1..N and done high after edge N+ACC_LATENCY+2. Each bubble adds one cycle.
- Bubble zeros: a sum consisting only of -0.0 terms may read +0.0.
- acc_n: never asserted on bubbles. It is asserted exactly once per sequence.

Test Plan:
- Reset, then start count=4 with terms 1.0,2.0,3.0,4.0 back-to-back -> acc_n high only with the 1.0 term; result=0x41200000; done single pulse after edge 9; xo=xu=ao=0.
- Same sequence with term_valid low for 2 cycles after the second term -> result=0x41200000, done delayed to edge 11, zeros fed during bubbles with acc_n=0.
- count=0 start -> result=0x00000000, done high after edge 1, acc_en never asserted.
- Two terms 0x7F7FFFFF and model acc_xo=1 on the second term's exit -> xo=1 at done; the following start clears xo to 0.
- Assert reset in mid-FEED after 2 of 5 terms -> all outputs 0 immediately, no done. A new start with count=1, term 5.0 gives result=0x40A00000.
- Drop clk_en for 3 cycles mid-DRAIN -> acc_en=0 and state frozen during those cycles; done arrives exactly 3 cycles later with the correct sum.

Source files
------------

// File: rtl/fp_acc_sequencer.sv
// Custom-instruction initiator for the FP accumulator core: streams COUNT terms in,
// follows them through the core pipeline, and returns the final sum with sticky flags.
module fp_acc_sequencer #(
  parameter int ACC_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             term_valid,
  input  logic [31:0]      term_data,
  output logic             term_ready,
  output logic [31:0]      acc_x,
  output logic             acc_n,
  output logic             acc_en,
  input  logic [31:0]      acc_r,
  input  logic             acc_xo,
  input  logic             acc_xu,
  input  logic             acc_ao,
  output logic [31:0]      result,
  output logic             xo,
  output logic             xu,
  output logic             ao,
  output logic             done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  typedef struct packed {
    logic term;
    logic last;
  } trk_t;

  state_t                state, state_nxt;
  trk_t [ACC_LATENCY:0]  trk_pipe;
  logic [CNT_W-1:0]      remaining;
  logic                  first;
  logic                  acc_en_q;
  logic                  accept;
  logic                  last_accept;
  logic                  exit_term;
  logic                  exit_last;

  assign term_ready  = (state == FEED) && clk_en;
  assign accept      = term_valid && term_ready;
  assign last_accept = accept && (remaining == CNT_W'(1));
  assign exit_term   = trk_pipe[ACC_LATENCY].term;
  assign exit_last   = trk_pipe[ACC_LATENCY].last;
  // The core only advances on enabled cycles, so a frozen sequencer must also freeze it.
  assign acc_en      = acc_en_q && clk_en;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : FEED;
      FEED:    if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (exit_term && exit_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      first     <= 1'b0;
      trk_pipe  <= '0;
      acc_x     <= '0;
      acc_n     <= 1'b0;
      acc_en_q  <= 1'b0;
      result    <= '0;
      xo        <= 1'b0;
      xu        <= 1'b0;
      ao        <= 1'b0;
      done      <= 1'b0;
    end else if (clk_en) begin
      trk_pipe <= {trk_pipe[ACC_LATENCY-1:0], accept, last_accept};
      done     <= (state == DONE);
      // Flags seen alongside a real term are folded in; bubble exits are ignored.
      if (exit_term) begin
        xo <= xo | acc_xo;
        xu <= xu | acc_xu;
        ao <= ao | acc_ao;
      end
      case (state)
        IDLE: begin
          acc_en_q <= 1'b0;
          acc_n    <= 1'b0;
          if (start) begin
            if (count != '0) begin
              remaining <= count;
              first     <= 1'b1;
              xo        <= 1'b0;
              xu        <= 1'b0;
              ao        <= 1'b0;
            end else begin
              result <= '0;
            end
          end
        end
        FEED, DRAIN: begin
          acc_en_q <= 1'b1;
          if (accept) begin
            acc_x     <= term_data;
            acc_n     <= first;
            first     <= 1'b0;
            remaining <= remaining - CNT_W'(1);
          end else begin
            acc_x <= '0;
            acc_n <= 1'b0;
          end
          if (state == DRAIN && exit_term && exit_last) result <= acc_r;
        end
        DONE: begin
          acc_en_q <= 1'b0;
          acc_n    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
